// File: rtl/ldpc_column_accumulator.sv
// LDPC column accumulator: sums NUM_ROWS row vectors of six signed 8-bit column
// messages into per-column signed totals, then holds the finished frame until the
// consumer takes it.
// Build option: define LDPC_COLUMN_ACCUM_SATURATE_EN for symmetric saturating adds;
// the default build wraps modulo 2^ACC_WIDTH.
module ldpc_column_accumulator #(
  parameter int unsigned NUM_ROWS  = 7,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [7:0]           i_data_0,
  input  logic [7:0]           i_data_1,
  input  logic [7:0]           i_data_2,
  input  logic [7:0]           i_data_3,
  input  logic [7:0]           i_data_4,
  input  logic [7:0]           i_data_5,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [ACC_WIDTH-1:0] o_sum_0,
  output logic [ACC_WIDTH-1:0] o_sum_1,
  output logic [ACC_WIDTH-1:0] o_sum_2,
  output logic [ACC_WIDTH-1:0] o_sum_3,
  output logic [ACC_WIDTH-1:0] o_sum_4,
  output logic [ACC_WIDTH-1:0] o_sum_5,
  output logic [5:0]           o_hard,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overflow
);

  localparam int unsigned AW   = ACC_WIDTH;
  localparam int unsigned CntW = $clog2(NUM_ROWS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_ROWS - 1);

  typedef logic [AW-1:0] acc_t;
  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [5:0][AW-1:0]   acc_q, acc_d;
  logic [5:0][AW-1:0]   sum_q, sum_d;
  logic                 ovf_q, ovf_d;

  logic [5:0][7:0]      data_in;
  logic [5:0][AW-1:0]   load_v;
  logic [5:0][AW-1:0]   add_v;
  logic                 accept;

  // Two's-complement add, either clamped symmetrically or wrapping.
  function automatic acc_t acc_add(input acc_t a, input acc_t b);
`ifdef LDPC_COLUMN_ACCUM_SATURATE_EN
    logic signed [AW:0] s;
    logic signed [AW:0] lim;
    logic signed [AW:0] nlim;
    s    = $signed({a[AW-1], a}) + $signed({b[AW-1], b});
    lim  = $signed({2'b00, {(AW - 1){1'b1}}});
    nlim = -lim;
    if (s > lim) return lim[AW-1:0];
    if (s < nlim) return nlim[AW-1:0];
    return s[AW-1:0];
`else
    return a + b;
`endif
  endfunction

  assign data_in = {i_data_5, i_data_4, i_data_3, i_data_2, i_data_1, i_data_0};
  assign o_ready = (state_q != StHold) | i_ready;
  assign accept  = i_valid & o_ready;

  // Candidate values: a fresh load (adding to zero applies the same clamp) or an add.
  always_comb begin
    load_v = '0;
    add_v  = '0;
    for (int k = 0; k < 6; k++) begin
      load_v[k] = acc_add('0, AW'($signed(data_in[k])));
      add_v[k]  = acc_add(acc_q[k], AW'($signed(data_in[k])));
    end
  end

  // Next-state logic: frame sequencing, accumulator update and overflow flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = load_v;
          cnt_d   = CntW'(1);
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d = add_v;
          if (cnt_q == LastCnt) begin
            sum_d   = add_v;
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (i_ready) begin
          if (i_valid) begin
            // Back-to-back frame: this row is row 1 of the next frame.
            acc_d   = load_v;
            cnt_d   = CntW'(1);
            state_d = StAccum;
          end else begin
            state_d = StIdle;
          end
        end else if (i_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid    = (state_q == StHold);
  assign o_overflow = ovf_q;
  assign o_sum_0    = sum_q[0];
  assign o_sum_1    = sum_q[1];
  assign o_sum_2    = sum_q[2];
  assign o_sum_3    = sum_q[3];
  assign o_sum_4    = sum_q[4];
  assign o_sum_5    = sum_q[5];

  // Hard decisions are the sign bits of the held (already clamped/wrapped) sums.
  always_comb begin
    o_hard = '0;
    for (int k = 0; k < 6; k++) o_hard[k] = sum_q[k][AW-1];
  end

endmodule

// File: tb/tb_ldpc_column_accumulator.sv
// Directed bench for ldpc_column_accumulator: a 12-bit instance covers the main
// behaviour and an 8-bit instance on the same stimulus covers clamp/wrap.
module tb_ldpc_column_accumulator;

  logic       clk;
  logic       rst_n;
  logic [7:0] d0, d1, d2, d3, d4, d5;
  logic       in_valid;
  logic       in_ready;

  logic        rdy12, vld12, ovf12;
  logic [11:0] s12_0, s12_1, s12_2, s12_3, s12_4, s12_5;
  logic [5:0]  hard12;
  logic        rdy8, vld8, ovf8;
  logic [7:0]  s8_0, s8_1, s8_2, s8_3, s8_4, s8_5;
  logic [5:0]  hard8;

  int n_checks = 0;
  int n_fails  = 0;

  ldpc_column_accumulator #(.NUM_ROWS(7), .ACC_WIDTH(12)) dut12 (
    .i_clock(clk), .i_reset(rst_n),
    .i_data_0(d0), .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4), .i_data_5(d5),
    .i_valid(in_valid), .o_ready(rdy12),
    .o_sum_0(s12_0), .o_sum_1(s12_1), .o_sum_2(s12_2),
    .o_sum_3(s12_3), .o_sum_4(s12_4), .o_sum_5(s12_5),
    .o_hard(hard12), .o_valid(vld12), .i_ready(in_ready), .o_overflow(ovf12)
  );

  ldpc_column_accumulator #(.NUM_ROWS(7), .ACC_WIDTH(8)) dut8 (
    .i_clock(clk), .i_reset(rst_n),
    .i_data_0(d0), .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4), .i_data_5(d5),
    .i_valid(in_valid), .o_ready(rdy8),
    .o_sum_0(s8_0), .o_sum_1(s8_1), .o_sum_2(s8_2),
    .o_sum_3(s8_3), .o_sum_4(s8_4), .o_sum_5(s8_5),
    .o_hard(hard8), .o_valid(vld8), .i_ready(in_ready), .o_overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_sums12(input string tag, input longint exp);
    check_eq({tag, " sum0"}, $signed(s12_0), exp);
    check_eq({tag, " sum1"}, $signed(s12_1), exp);
    check_eq({tag, " sum2"}, $signed(s12_2), exp);
    check_eq({tag, " sum3"}, $signed(s12_3), exp);
    check_eq({tag, " sum4"}, $signed(s12_4), exp);
    check_eq({tag, " sum5"}, $signed(s12_5), exp);
  endtask

  task automatic check_sums8(input string tag, input longint exp);
    check_eq({tag, " sum0"}, $signed(s8_0), exp);
    check_eq({tag, " sum3"}, $signed(s8_3), exp);
    check_eq({tag, " sum5"}, $signed(s8_5), exp);
  endtask

  task automatic set_data(input int v);
    d0 = 8'(v); d1 = 8'(v); d2 = 8'(v); d3 = 8'(v); d4 = 8'(v); d5 = 8'(v);
  endtask

  // Present one row for one clock; inputs change 1 time unit after the edge.
  task automatic send_row(input int v);
    set_data(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b1;
    set_data(0);
    #2;
    check_eq("reset valid", vld12, 0);
    check_eq("reset ready", rdy12, 1);
    check_eq("reset ovf", ovf12, 0);
    check_eq("reset hard", hard12, 0);
    check_sums12("reset", 0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    check_eq("post-reset ready", rdy12, 1);

    // Seven rows of +10.
    for (int r = 0; r < 6; r++) send_row(10);
    check_eq("mid-frame valid", vld12, 0);
    send_row(10);
    check_eq("r10 valid", vld12, 1);
    check_sums12("r10", 70);
    check_eq("r10 hard", hard12, 0);
    idle_cycles(1);
    check_eq("r10 released", vld12, 0);
    check_sums12("r10 held", 70);

    // Seven rows of -128.
    for (int r = 0; r < 7; r++) send_row(-128);
    check_eq("rneg valid", vld12, 1);
    check_sums12("rneg", -896);
    check_eq("rneg hard", hard12, 6'b111111);
    idle_cycles(1);

    // Seven rows of +100: 12-bit holds 700, 8-bit clamps or wraps.
    for (int r = 0; r < 7; r++) send_row(100);
    check_sums12("r100 w12", 700);
    check_eq("r100 w8 valid", vld8, 1);
`ifdef LDPC_COLUMN_ACCUM_SATURATE_EN
    check_sums8("r100 w8", 127);
    check_eq("r100 w8 hard", hard8, 6'b000000);
`else
    check_sums8("r100 w8", -68);
    check_eq("r100 w8 hard", hard8, 6'b111111);
`endif
    idle_cycles(1);

    // Consumer stalls in HOLD; a row arriving meanwhile is dropped.
    for (int r = 0; r < 6; r++) send_row(3);
    in_ready = 1'b0;
    send_row(3);
    check_eq("stall valid", vld12, 1);
    check_eq("stall ready", rdy12, 0);
    idle_cycles(1);
    send_row(50);
    idle_cycles(3);
    check_eq("stall ovf", ovf12, 1);
    check_eq("stall still valid", vld12, 1);
    check_sums12("stall", 21);
    in_ready = 1'b1;
    idle_cycles(1);
    check_eq("stall released", vld12, 0);
    check_eq("ovf sticky", ovf12, 1);

    // Back-to-back: the releasing cycle also carries row 1 of the next frame.
    for (int r = 0; r < 6; r++) send_row(4);
    in_ready = 1'b0;
    send_row(4);
    check_sums12("b2b first", 28);
    in_ready = 1'b1;
    send_row(5);
    check_eq("b2b released", vld12, 0);
    for (int r = 0; r < 5; r++) send_row(0);
    check_eq("b2b not done", vld12, 0);
    send_row(0);
    check_eq("b2b valid", vld12, 1);
    check_sums12("b2b", 5);
    idle_cycles(1);

    // Reset mid-frame clears everything at once.
    for (int r = 0; r < 3; r++) send_row(9);
    rst_n = 1'b0;
    #1;
    check_eq("async rst valid", vld12, 0);
    check_eq("async rst ovf", ovf12, 0);
    check_eq("async rst ready", rdy12, 1);
    check_eq("async rst hard", hard12, 0);
    check_sums12("async rst", 0);
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(1);
    for (int r = 0; r < 7; r++) send_row(1);
    check_eq("fresh valid", vld12, 1);
    check_sums12("fresh", 7);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
